// File: rtl/ms_timer_sched_pkg.sv
// Shared types and helpers for the millisecond timer scheduler.
// Holds the channel/sweep state encodings and the prescaler sizing functions.
package ms_timer_sched_pkg;

    typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_t;

    typedef enum logic {SW_IDLE = 1'b0, SW_SWEEP = 1'b1} sw_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Counter width for a 0..DIV-1 prescaler, never narrower than one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned clk_hz, input int unsigned tick_hz);
        int unsigned d;
        int unsigned w;
        d = calc_div(clk_hz, tick_hz);
        w = $clog2(d);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/ms_timer_sched_if.sv
// Consumer-facing bundle of the timer scheduler: requests in, status and tick out.
// The consumer side drives START/LOAD_MS/CLEAR; the timer drives BUSY/DONE/TICK1K.
interface ms_timer_sched_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 16
);
    logic [NCH-1:0]    START;
    logic [NCH*CW-1:0] LOAD_MS;
    logic [NCH-1:0]    CLEAR;
    logic [NCH-1:0]    BUSY;
    logic [NCH-1:0]    DONE;
    logic              TICK1K;

    modport master (
        output START, LOAD_MS, CLEAR,
        input  BUSY, DONE, TICK1K
    );

    modport slave (
        input  START, LOAD_MS, CLEAR,
        output BUSY, DONE, TICK1K
    );
endinterface

// File: rtl/ms_timer_sched_tick_prescaler.sv
// Divides the board clock down to a one-cycle tick enable every CLK_HZ/TICK_HZ cycles.
// Reusable by any block that needs a slow enable without creating a derived clock.
module ms_timer_sched_tick_prescaler #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic CLK50M,
    input  logic RST,
    output logic TICK1K
);
    import ms_timer_sched_pkg::*;

    localparam int unsigned DIV  = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned CNTW = calc_cnt_w(CLK_HZ, TICK_HZ);
    localparam logic [CNTW-1:0] LAST = CNTW'(DIV - 1);

    logic [CNTW-1:0] cnt;

    // Tick is registered, so it shows up the cycle after the counter hits its last value.
    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            TICK1K <= 1'b0;
        end else begin
            TICK1K <= (cnt == LAST);
            cnt    <= (cnt == LAST) ? '0 : cnt + CNTW'(1);
        end
    end

endmodule

// File: rtl/ms_timer_sched.sv
// Multi-channel millisecond timer: one shared decrementer swept round-robin over
// all channels on each tick, with per-channel start/clear and a one-cycle DONE pulse.
module ms_timer_sched #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned NCH     = 4,
    parameter int unsigned CW      = 16
) (
    input  logic              CLK50M,
    input  logic              RST,
    ms_timer_sched_if.slave   bus
);
    import ms_timer_sched_pkg::*;

    localparam int unsigned    IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NCH - 1);

    logic            tick;
    sw_state_t       sw_state;
    sw_state_t       sw_next;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_next;
    logic [NCH-1:0]  svc;

    ms_timer_sched_tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .CLK50M (CLK50M),
        .RST    (RST),
        .TICK1K (tick)
    );

    assign bus.TICK1K = tick;

    // Sweep state register.
    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            sw_state <= SW_IDLE;
            idx      <= '0;
        end else begin
            sw_state <= sw_next;
            idx      <= idx_next;
        end
    end

    // Sweep next state: one channel per cycle, NCH cycles per tick.
    always_comb begin
        sw_next  = sw_state;
        idx_next = idx;
        case (sw_state)
            SW_IDLE: begin
                if (tick) begin
                    sw_next  = SW_SWEEP;
                    idx_next = '0;
                end
            end
            SW_SWEEP: begin
                if (idx == LAST_IDX) begin
                    sw_next  = SW_IDLE;
                    idx_next = '0;
                end else begin
                    idx_next = idx + IW'(1);
                end
            end
            default: begin
                sw_next  = SW_IDLE;
                idx_next = '0;
            end
        endcase
    end

    // Sweep outputs: one-hot service strobe for the channel owning the decrementer.
    always_comb begin
        svc = '0;
        if (sw_state == SW_SWEEP) begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (idx == IW'(i)) begin
                    svc[i] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
        ch_state_t       st;
        ch_state_t       st_nx;
        logic [CW-1:0]   rem;
        logic [CW-1:0]   rem_nx;
        logic            done_q;
        logic            done_nx;
        logic [CW-1:0]   load;

        assign load = bus.LOAD_MS[g*CW +: CW];

        always_ff @(posedge CLK50M or posedge RST) begin
            if (RST) begin
                st     <= CH_IDLE;
                rem    <= '0;
                done_q <= 1'b0;
            end else begin
                st     <= st_nx;
                rem    <= rem_nx;
                done_q <= done_nx;
            end
        end

        // Clear beats start, start beats the sweep decrement.
        always_comb begin
            st_nx   = st;
            rem_nx  = rem;
            done_nx = 1'b0;
            if (bus.CLEAR[g]) begin
                st_nx  = CH_IDLE;
                rem_nx = '0;
            end else if (bus.START[g]) begin
                if (load == '0) begin
                    st_nx   = CH_IDLE;
                    rem_nx  = '0;
                    done_nx = 1'b1;
                end else begin
                    st_nx  = CH_RUN;
                    rem_nx = load;
                end
            end else if (svc[g] && (st == CH_RUN)) begin
                if (rem == CW'(1)) begin
                    st_nx   = CH_IDLE;
                    rem_nx  = '0;
                    done_nx = 1'b1;
                end else begin
                    rem_nx = rem - CW'(1);
                end
            end
        end

        assign bus.BUSY[g] = (st == CH_RUN);
        assign bus.DONE[g] = done_q;
    end

endmodule

// File: tb/tb_ms_timer_sched.sv
// Scenario bench for ms_timer_sched at DIV=10: expected DONE/BUSY windows are queued
// when a request is driven and retired as the DUT reaches them.
module tb_ms_timer_sched;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 16;
    localparam int unsigned DIV = 10;

    typedef struct {
        int ch;
        int st;
        int done;
        bit run;
    } exp_t;

    logic CLK50M = 1'b0;
    logic RST    = 1'b1;
    int   cyc;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    exp_t sb[$];

    ms_timer_sched_if #(.NCH(NCH), .CW(CW)) bus();

    ms_timer_sched #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .NCH     (NCH),
        .CW      (CW)
    ) dut (
        .CLK50M (CLK50M),
        .RST    (RST),
        .bus    (bus)
    );

    always #5 CLK50M = ~CLK50M;

    // Cycle index since reset release; cycle k follows the k-th rising edge.
    always @(posedge CLK50M or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Ticks land on multiples of DIV; channel ch is serviced at tick+1+ch,
    // so a request driven in cycle s sees every tick t >= s-ch.
    function automatic int first_done(input int ch, input int s, input int n);
        int t;
        t = DIV;
        while (t < s - ch) t += DIV;
        return t + (n - 1) * DIV + 2 + ch;
    endfunction

    function automatic logic [NCH-1:0] exp_done(input int c);
        logic [NCH-1:0] v;
        v = '0;
        foreach (sb[k]) if (sb[k].done == c) v[sb[k].ch] = 1'b1;
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_busy(input int c);
        logic [NCH-1:0] v;
        v = '0;
        foreach (sb[k]) if (sb[k].run && sb[k].st < c && c < sb[k].done) v[sb[k].ch] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_tick(input int c);
        return (c > 0) && ((c % DIV) == 0);
    endfunction

    task automatic drop(input int ch);
        for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].ch == ch) sb.delete(k);
    endtask

    task automatic retire(input int c);
        for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].done <= c) sb.delete(k);
    endtask

    task automatic push_start(input int ch, input int n);
        exp_t e;
        bus.START[ch] = 1'b1;
        bus.LOAD_MS[ch*CW +: CW] = CW'(n);
        drop(ch);
        e.ch  = ch;
        e.st  = cyc;
        e.run = (n != 0);
        e.done = (n == 0) ? cyc + 1 : first_done(ch, cyc, n);
        sb.push_back(e);
    endtask

    task automatic push_clear(input int ch);
        bus.CLEAR[ch] = 1'b1;
        drop(ch);
    endtask

    task automatic idle_inputs();
        bus.START   = '0;
        bus.CLEAR   = '0;
        bus.LOAD_MS = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        sb.delete();
        repeat (2) @(negedge CLK50M);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        while (cyc <= 35) begin
            n_cmp++; if (bus.TICK1K !== exp_tick(cyc)) begin n_bad++; $display("FAIL rst_tick cyc=%0d got=%b exp=%b", cyc, bus.TICK1K, exp_tick(cyc)); end
            n_cmp++; if (bus.BUSY !== exp_busy(cyc)) begin n_bad++; $display("FAIL rst_busy cyc=%0d got=%b exp=%b", cyc, bus.BUSY, exp_busy(cyc)); end
            n_cmp++; if (bus.DONE !== exp_done(cyc)) begin n_bad++; $display("FAIL rst_done cyc=%0d got=%b exp=%b", cyc, bus.DONE, exp_done(cyc)); end
            retire(cyc);
            idle_inputs();
            @(negedge CLK50M);
        end
    endtask

    task automatic test_single();
        do_reset();
        while (cyc <= 50) begin
            n_cmp++; if (bus.TICK1K !== exp_tick(cyc)) begin n_bad++; $display("FAIL single_tick cyc=%0d got=%b exp=%b", cyc, bus.TICK1K, exp_tick(cyc)); end
            n_cmp++; if (bus.BUSY !== exp_busy(cyc)) begin n_bad++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, bus.BUSY, exp_busy(cyc)); end
            n_cmp++; if (bus.DONE !== exp_done(cyc)) begin n_bad++; $display("FAIL single_done cyc=%0d got=%b exp=%b", cyc, bus.DONE, exp_done(cyc)); end
            retire(cyc);
            idle_inputs();
            if (cyc == 12) push_start(0, 3);
            @(negedge CLK50M);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        while (cyc <= 25) begin
            n_cmp++; if (bus.BUSY !== exp_busy(cyc)) begin n_bad++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, bus.BUSY, exp_busy(cyc)); end
            n_cmp++; if (bus.DONE !== exp_done(cyc)) begin n_bad++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", cyc, bus.DONE, exp_done(cyc)); end
            retire(cyc);
            idle_inputs();
            if (cyc == 5) for (int c = 0; c < int'(NCH); c++) push_start(c, 1);
            @(negedge CLK50M);
        end
    endtask

    task automatic test_zero_load();
        do_reset();
        while (cyc <= 15) begin
            n_cmp++; if (bus.BUSY !== exp_busy(cyc)) begin n_bad++; $display("FAIL zero_busy cyc=%0d got=%b exp=%b", cyc, bus.BUSY, exp_busy(cyc)); end
            n_cmp++; if (bus.DONE !== exp_done(cyc)) begin n_bad++; $display("FAIL zero_done cyc=%0d got=%b exp=%b", cyc, bus.DONE, exp_done(cyc)); end
            retire(cyc);
            idle_inputs();
            if (cyc == 7) push_start(2, 0);
            @(negedge CLK50M);
        end
    endtask

    task automatic test_clear();
        do_reset();
        while (cyc <= 70) begin
            n_cmp++; if (bus.BUSY !== exp_busy(cyc)) begin n_bad++; $display("FAIL clear_busy cyc=%0d got=%b exp=%b", cyc, bus.BUSY, exp_busy(cyc)); end
            n_cmp++; if (bus.DONE !== exp_done(cyc)) begin n_bad++; $display("FAIL clear_done cyc=%0d got=%b exp=%b", cyc, bus.DONE, exp_done(cyc)); end
            retire(cyc);
            idle_inputs();
            if (cyc == 3) push_start(1, 5);
            if (cyc == 23) begin
                push_start(1, 2);
                push_clear(1);
            end
            @(negedge CLK50M);
        end
    endtask

    task automatic test_restart();
        do_reset();
        while (cyc <= 55) begin
            n_cmp++; if (bus.BUSY !== exp_busy(cyc)) begin n_bad++; $display("FAIL restart_busy cyc=%0d got=%b exp=%b", cyc, bus.BUSY, exp_busy(cyc)); end
            n_cmp++; if (bus.DONE !== exp_done(cyc)) begin n_bad++; $display("FAIL restart_done cyc=%0d got=%b exp=%b", cyc, bus.DONE, exp_done(cyc)); end
            retire(cyc);
            idle_inputs();
            if (cyc == 2)  push_start(3, 4);
            if (cyc == 24) push_start(3, 2);
            @(negedge CLK50M);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        while (cyc < 30) begin
            n_cmp++; if (bus.BUSY !== exp_busy(cyc)) begin n_bad++; $display("FAIL arst_pre_busy cyc=%0d got=%b exp=%b", cyc, bus.BUSY, exp_busy(cyc)); end
            retire(cyc);
            idle_inputs();
            if (cyc == 3) for (int c = 0; c < 3; c++) push_start(c, 5);
            @(negedge CLK50M);
        end
        n_cmp++; if (bus.TICK1K !== 1'b1) begin n_bad++; $display("FAIL arst_pre_tick cyc=%0d got=%b exp=1", cyc, bus.TICK1K); end
        #2 RST = 1'b1;
        sb.delete();
        #1;
        n_cmp++; if (bus.BUSY !== '0) begin n_bad++; $display("FAIL arst_busy got=%b exp=0000", bus.BUSY); end
        n_cmp++; if (bus.DONE !== '0) begin n_bad++; $display("FAIL arst_done got=%b exp=0000", bus.DONE); end
        n_cmp++; if (bus.TICK1K !== 1'b0) begin n_bad++; $display("FAIL arst_tick got=%b exp=0", bus.TICK1K); end
        repeat (2) @(negedge CLK50M);
        RST = 1'b0;
        while (cyc <= 60) begin
            n_cmp++; if (bus.TICK1K !== exp_tick(cyc)) begin n_bad++; $display("FAIL arst_post_tick cyc=%0d got=%b exp=%b", cyc, bus.TICK1K, exp_tick(cyc)); end
            n_cmp++; if (bus.BUSY !== exp_busy(cyc)) begin n_bad++; $display("FAIL arst_post_busy cyc=%0d got=%b exp=%b", cyc, bus.BUSY, exp_busy(cyc)); end
            n_cmp++; if (bus.DONE !== exp_done(cyc)) begin n_bad++; $display("FAIL arst_post_done cyc=%0d got=%b exp=%b", cyc, bus.DONE, exp_done(cyc)); end
            @(negedge CLK50M);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout time=%0t compared=%0d", $time, n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_load();
        test_clear();
        test_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
